gate_truth_table_driver: RTL and testbench

- Sequential stimulus/checker for the two-input, one-output logic-gate lab blocks.
- Drives I1 and I2, samples O, and reports the observed truth table and pass/fail against an expected table.
- Sits on the tester side of the gate interface: instantiated next to a gate module on the lab board or bench.

---
 rtl/gate_truth_table_driver_if.sv | 26 ++
 rtl/gate_truth_table_driver.sv | 149 ++++++++++++++
 tb/tb_gate_truth_table_driver.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_table_driver_if.sv
// Purpose : bundles the tester-side gate bus (I1/I2/O) with the sweep control
//           and result signals of gate_truth_table_driver.
// Ports   : master = driver side (drives I1/I2 and results, reads start/abort/O);
//           slave  = environment side (gate under test plus sweep controller).
interface gate_truth_table_driver_if;
  logic       start;     // level-sampled sweep request
  logic       abort;     // cancels a sweep in progress
  logic       I1;        // gate input A
  logic       I2;        // gate input B
  logic       O;         // gate output under test
  logic       busy;      // sweep in progress
  logic       done;      // one-cycle completion pulse
  logic       pass;      // observed table equals the expected table
  logic [3:0] observed;  // captured O per vector index
  logic [3:0] mismatch;  // observed ^ expected

  modport master (
    input  start, abort, O,
    output I1, I2, busy, done, pass, observed, mismatch
  );

  modport slave (
    output start, abort, O,
    input  I1, I2, busy, done, pass, observed, mismatch
  );
endinterface

// File: rtl/gate_truth_table_driver.sv
// Purpose : sweeps the four input vectors of a 2-in/1-out gate, captures O per vector
//           and grades the captured truth table against EXPECTED.
// Latency : start edge to done edge = 4*SETTLE_CYCLES+1 cycles; no backpressure,
//           start is level-sampled in IDLE only and abort cancels a running sweep.
// Ports   : clk, rst_n (async, active-low); drv (master modport): start/abort/O in,
//           I1/I2/busy/done/pass/observed/mismatch out, all registered.
module gate_truth_table_driver #(
  parameter int unsigned SETTLE_CYCLES = 2,       // 1..255 cycles per vector
  parameter logic [3:0]  EXPECTED      = 4'b1000  // bit k = expected O for vector k
) (
  input logic                        clk,
  input logic                        rst_n,
  gate_truth_table_driver_if.master  drv
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  // Final count of a vector window; O is sampled on the edge where cnt reaches it.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       i1_q, i1_d;
  logic       i2_q, i2_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] observed_q, observed_d;
  logic [3:0] mismatch_q, mismatch_d;
  logic [1:0] idx_nxt;

  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    i1_d       = i1_q;
    i2_d       = i2_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    observed_d = observed_q;
    mismatch_d = mismatch_q;

    case (state_q)
      ST_IDLE: begin
        i1_d   = 1'b0;
        i2_d   = 1'b0;
        busy_d = 1'b0;
        // abort outranks start even in IDLE
        if (drv.start && !drv.abort) begin
          state_d    = ST_SETTLE;
          idx_d      = 2'd0;
          cnt_d      = 8'd0;
          busy_d     = 1'b1;
          observed_d = 4'b0000;
          mismatch_d = 4'b0000;
          pass_d     = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (drv.abort) begin
          // Partial captures are dropped so an aborted sweep reports nothing.
          state_d    = ST_IDLE;
          idx_d      = 2'd0;
          cnt_d      = 8'd0;
          i1_d       = 1'b0;
          i2_d       = 1'b0;
          busy_d     = 1'b0;
          observed_d = 4'b0000;
          mismatch_d = 4'b0000;
          pass_d     = 1'b0;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          observed_d[idx_q] = drv.O;
          if (idx_q != 2'd3) begin
            // Next vector goes out on the same edge that samples this one.
            idx_d        = idx_nxt;
            cnt_d        = 8'd0;
            {i1_d, i2_d} = idx_nxt;
          end else begin
            state_d = ST_REPORT;
          end
        end
      end

      ST_REPORT: begin
        // observed_q is complete here; grade it and release the gate inputs.
        state_d    = ST_IDLE;
        idx_d      = 2'd0;
        cnt_d      = 8'd0;
        i1_d       = 1'b0;
        i2_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        mismatch_d = observed_q ^ EXPECTED;
        pass_d     = (observed_q == EXPECTED);
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        i1_d    = 1'b0;
        i2_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 8'd0;
      i1_q       <= 1'b0;
      i2_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      observed_q <= 4'b0000;
      mismatch_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      observed_q <= observed_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign drv.I1       = i1_q;
  assign drv.I2       = i2_q;
  assign drv.busy     = busy_q;
  assign drv.done     = done_q;
  assign drv.pass     = pass_q;
  assign drv.observed = observed_q;
  assign drv.mismatch = mismatch_q;

endmodule

// File: tb/tb_gate_truth_table_driver.sv
// Purpose : directed bench for gate_truth_table_driver with three configurations:
//           A = defaults on an AND gate, B = XOR expectation on an OR gate,
//           C = one-cycle settle on an XOR gate.
module tb_gate_truth_table_driver;

  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_XOR = 4'b0110;

  typedef struct {
    logic [3:0] obs;
    logic [3:0] mis;
    logic       pass;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [2:0] start_r;
  logic [2:0] abort_r;
  logic [2:0] i1_w, i2_w, busy_w, done_w, pass_w;
  logic [3:0] obs_w [3];
  logic [3:0] mis_w [3];

  int   checks;
  int   errors;
  exp_t sb [$];

  gate_truth_table_driver_if if_a ();
  gate_truth_table_driver_if if_b ();
  gate_truth_table_driver_if if_c ();

  gate_truth_table_driver u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .drv   (if_a.master)
  );

  gate_truth_table_driver #(.SETTLE_CYCLES(2), .EXPECTED(TT_XOR)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .drv   (if_b.master)
  );

  gate_truth_table_driver #(.SETTLE_CYCLES(1), .EXPECTED(TT_XOR)) u_c (
    .clk   (clk),
    .rst_n (rst_n),
    .drv   (if_c.master)
  );

  // Gate models: combinational O from the driven inputs.
  assign if_a.O = (if_a.I1 & if_a.I2);
  assign if_b.O = (if_b.I1 | if_b.I2);
  assign if_c.O = (if_c.I1 ^ if_c.I2);

  assign if_a.start = start_r[0];
  assign if_b.start = start_r[1];
  assign if_c.start = start_r[2];
  assign if_a.abort = abort_r[0];
  assign if_b.abort = abort_r[1];
  assign if_c.abort = abort_r[2];

  assign i1_w   = {if_c.I1,   if_b.I1,   if_a.I1};
  assign i2_w   = {if_c.I2,   if_b.I2,   if_a.I2};
  assign busy_w = {if_c.busy, if_b.busy, if_a.busy};
  assign done_w = {if_c.done, if_b.done, if_a.done};
  assign pass_w = {if_c.pass, if_b.pass, if_a.pass};
  assign obs_w[0] = if_a.observed;
  assign obs_w[1] = if_b.observed;
  assign obs_w[2] = if_c.observed;
  assign mis_w[0] = if_a.mismatch;
  assign mis_w[1] = if_b.mismatch;
  assign mis_w[2] = if_c.mismatch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start on instance d, checks the vector sequence every cycle, then
  // compares the completion against the scoreboard entry pushed at start.
  task automatic sweep(input int d, input int s, input logic [3:0] tt, input logic [3:0] expv);
    exp_t e;
    int   n;
    e.obs  = tt;
    e.mis  = tt ^ expv;
    e.pass = (tt == expv);
    e.lat  = 4 * s + 1;
    sb.push_back(e);
    @(negedge clk);
    start_r[d] = 1'b1;
    @(negedge clk);
    start_r[d] = 1'b0;
    n = 0;
    while (done_w[d] !== 1'b1 && n < 60) begin
      if (n < 4 * s) begin
        chk($sformatf("vec%0d_n%0d", d, n), {30'd0, i1_w[d], i2_w[d]}, 32'(n / s));
        chk($sformatf("busy%0d_n%0d", d, n), 32'(busy_w[d]), 32'd1);
      end
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen%0d", d), 32'(done_w[d]), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty_at_done", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("latency%0d", d), 32'(n), 32'(e.lat));
      chk($sformatf("observed%0d", d), 32'(obs_w[d]), 32'(e.obs));
      chk($sformatf("mismatch%0d", d), 32'(mis_w[d]), 32'(e.mis));
      chk($sformatf("pass%0d", d), 32'(pass_w[d]), 32'(e.pass));
    end
    chk($sformatf("busy_at_done%0d", d), 32'(busy_w[d]), 32'd0);
    chk($sformatf("inputs_at_done%0d", d), {30'd0, i1_w[d], i2_w[d]}, 32'd0);
    @(negedge clk);
    chk($sformatf("done_single%0d", d), 32'(done_w[d]), 32'd0);
    chk($sformatf("pass_hold%0d", d), 32'(pass_w[d]), 32'(tt == expv));
  endtask

  initial begin
    exp_t e;
    logic seen;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start_r = 3'b000;
    abort_r = 3'b000;

    // Reset values on all instances.
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_busy%0d", d), 32'(busy_w[d]), 32'd0);
      chk($sformatf("rst_done%0d", d), 32'(done_w[d]), 32'd0);
      chk($sformatf("rst_pass%0d", d), 32'(pass_w[d]), 32'd0);
      chk($sformatf("rst_in%0d", d), {30'd0, i1_w[d], i2_w[d]}, 32'd0);
      chk($sformatf("rst_obs%0d", d), 32'(obs_w[d]), 32'd0);
      chk($sformatf("rst_mis%0d", d), 32'(mis_w[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Main function across three configurations.
    sweep(0, 2, TT_AND, TT_AND);
    sweep(1, 2, TT_OR,  TT_XOR);
    sweep(2, 1, TT_XOR, TT_XOR);

    // start held for 20 edges: back-to-back sweeps, done at edges 9 and 19.
    e.obs = TT_AND; e.mis = 4'b0000; e.pass = 1'b1; e.lat = 9;
    sb.push_back(e);
    e.lat = 19;
    sb.push_back(e);
    @(negedge clk);
    start_r[0] = 1'b1;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (n == 19) start_r[0] = 1'b0;
      if (done_w[0] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("held_extra_done", 32'(n), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("held_latency", 32'(n), 32'(e.lat));
          chk("held_observed", 32'(obs_w[0]), 32'(e.obs));
          chk("held_pass", 32'(pass_w[0]), 32'(e.pass));
        end
      end
      if (n == 10) begin
        chk("held_clear_obs", 32'(obs_w[0]), 32'd0);
        chk("held_clear_pass", 32'(pass_w[0]), 32'd0);
        chk("held_restart_busy", 32'(busy_w[0]), 32'd1);
      end
    end
    chk("held_sb_drained", 32'(sb.size()), 32'd0);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    start_r[1] = 1'b1;
    abort_r[1] = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    abort_r[1] = 1'b0;
    chk("start_abort_idle_busy", 32'(busy_w[1]), 32'd0);
    chk("start_abort_idle_in", {30'd0, i1_w[1], i2_w[1]}, 32'd0);

    // abort during vector 2 on the OR instance (vectors 0,1 already captured).
    @(negedge clk);
    start_r[1] = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_vec", {30'd0, i1_w[1], i2_w[1]}, 32'd2);
    chk("abort_pre_obs", 32'(obs_w[1]), 32'h2);
    abort_r[1] = 1'b1;
    @(negedge clk);
    abort_r[1] = 1'b0;
    chk("abort_busy", 32'(busy_w[1]), 32'd0);
    chk("abort_in", {30'd0, i1_w[1], i2_w[1]}, 32'd0);
    chk("abort_obs", 32'(obs_w[1]), 32'd0);
    chk("abort_pass", 32'(pass_w[1]), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_w[1] !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    sweep(1, 2, TT_OR, TT_XOR);

    // Asynchronous reset mid-sweep, between edges.
    @(negedge clk);
    start_r[1] = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_pre_obs", 32'(obs_w[1]), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in", {30'd0, i1_w[1], i2_w[1]}, 32'd0);
    chk("rst_mid_busy", 32'(busy_w[1]), 32'd0);
    chk("rst_mid_obs", 32'(obs_w[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(1, 2, TT_OR, TT_XOR);
    sweep(0, 2, TT_AND, TT_AND);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
